// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

    // Register index width of the core's register file.
    localparam int REG_FILE_DEPTH = 4;

    // Width of the stall-cycle performance counter.
    localparam int HZ_CNT_W = 16;

    // Sequencer state encodings; plain constants keep them compatible with older netlists.
    localparam logic [0:0] HZ_STATE_RUN      = 1'b0;
    localparam logic [0:0] HZ_STATE_MEM_WAIT = 1'b1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle between the core datapath and the hazard sequencer.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_FILE_DEPTH,
    parameter int CNT_W = HZ_CNT_W
);
    logic             fwd_mode;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             freeze_pc;
    logic             bubble_exe;
    logic             flush_if;
    logic             freeze_all;
    logic             fwd_enable;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath side: presents pipeline status, consumes the control strobes.
    modport master (
        output fwd_mode, id_valid, id_src1, id_src2, id_two_src,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clr,
        input  freeze_pc, bubble_exe, flush_if, freeze_all, fwd_enable, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  fwd_mode, id_valid, id_src1, id_src2, id_two_src,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clr,
        output freeze_pc, bubble_exe, flush_if, freeze_all, fwd_enable, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Register dependency compare of the ID sources against the EXE and MEM destinations.
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_FILE_DEPTH
)
(
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hz_exe,
    output logic             hz_mem
);

    // A match only counts when the older instruction actually writes back; R15 is not special.
    always_comb begin
        hz_exe = exe_wb_en && ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
        hz_mem = mem_wb_en && ((src1 == mem_dest) || (two_src && (src2 == mem_dest)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/flush control, forwarding enable and stall counter.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  RUN      | normal issue; hazards and branches steer IF/ID/EXE
//  MEM_WAIT | SRAM access outstanding; whole pipeline frozen
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_FILE_DEPTH,
    parameter int CNT_W = HZ_CNT_W
)
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             hz_exe;
    logic             hz_mem;
    logic             hz;
    logic             br;
    logic             frz_all;
    logic             frz_pc;
    logic             fwd_en;
    logic [CNT_W-1:0] cnt;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .src1      (bus.id_src1),
        .src2      (bus.id_src2),
        .two_src   (bus.id_two_src),
        .exe_dest  (bus.exe_dest),
        .exe_wb_en (bus.exe_wb_en),
        .mem_dest  (bus.mem_dest),
        .mem_wb_en (bus.mem_wb_en),
        .hz_exe    (hz_exe),
        .hz_mem    (hz_mem)
    );

    // Combinational control; everything is gated by rst so outputs read 0 while held in reset.
    always_comb begin
        if (state == HZ_STATE_RUN)
            frz_all = rst && bus.mem_req && !bus.mem_ready;
        else
            frz_all = rst;
        // With forwarding on, only a load feeding ID still needs a stall.
        hz     = rst && bus.id_valid && !frz_all &&
                 (fwd_en ? (hz_exe && bus.exe_mem_read) : (hz_exe || hz_mem));
        // A branch seen while frozen stays in EXE and is taken on the first free cycle.
        br     = rst && bus.branch_taken && !frz_all;
        frz_pc = hz && !br;
    end

    // Next-state: leave RUN on an SRAM access that is not ready; MEM_WAIT holds through the ready cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            HZ_STATE_RUN:      if (bus.mem_req && !bus.mem_ready) state_nxt = HZ_STATE_MEM_WAIT;
            HZ_STATE_MEM_WAIT: if (bus.mem_ready)                 state_nxt = HZ_STATE_RUN;
            default:                                              state_nxt = HZ_STATE_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HZ_STATE_RUN;
        else      state <= state_nxt;
    end

    // Forwarding mode only switches on a quiet RUN cycle so no in-flight decision sees it change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fwd_en <= 1'b0;
        else if ((state == HZ_STATE_RUN) && !hz && !br && !frz_all)
            fwd_en <= bus.fwd_mode;
    end

    // Saturating stall-cycle counter; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (bus.cnt_clr)
            cnt <= '0;
        else if ((frz_pc || frz_all) && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    // Output drive.
    always_comb begin
        bus.freeze_all = frz_all;
        bus.freeze_pc  = frz_pc;
        bus.bubble_exe = hz || br;
        bus.flush_if   = br;
        bus.fwd_enable = fwd_en;
        bus.stall_cnt  = cnt;
    end

endmodule
